pll_reset_sequencer: RTL and testbench

- Sequences the iCE40 PLL after power-up, and generates the core reset for logic clocked from the PLL output.
- Pulses the PLL RESETB, waits for LOCK, and qualifies LOCK as stable before releasing the core reset.
- Re-runs the sequence on loss of lock, on lock timeout, or on software request.
- Runs on the board reference clock (48 MHz), which is always present, unlike the PLL output.

---
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - iCE40 PLL reset/lock sequencer and core reset generator
//
// Runs on the always-present board reference clock. Pulses the PLL RESETB,
// waits for a synchronized LOCK, qualifies it as stable, then releases the
// core reset. Loss of lock, a lock timeout or a restart request re-runs the
// whole sequence.
//
// Ports:
//   clock         in   reference clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   locked        in   PLL LOCK pin (asynchronous, synchronized internally)
//   restart       in   single-cycle request to re-run the sequence
//   clear_status  in   clears lock_lost and retry_count
//   pll_resetb    out  PLL RESETB, low = PLL held in reset
//   core_reset_n  out  registered active-low core reset
//   ready         out  high only while in RUN
//   lock_lost     out  sticky: lock dropped while in RUN
//   retry_count   out  saturating count of lock timeouts
module pll_reset_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_WIDTH     = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  input  logic       clear_status,
  output logic       pll_resetb,
  output logic       core_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RESET_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state;
  state_t               state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic                 locked_m;
  logic                 locked_s;
  logic                 set_lock_lost;
  logic                 timeout_evt;

  // Two-flop synchronizer for the asynchronous LOCK pin.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt + 1'b1;
    set_lock_lost = 1'b0;
    timeout_evt   = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RESET_LAST) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n     = PLL_RST;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) state_n = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_n = RUN;
      end
      RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n       = PLL_RST;
          set_lock_lost = 1'b1;
        end
      end
      default: state_n = PLL_RST;
    endcase
    // restart overrides everything, and is not a lock loss or a timeout.
    if (restart) begin
      state_n       = PLL_RST;
      set_lock_lost = 1'b0;
      timeout_evt   = 1'b0;
    end
    // Counter starts from zero on every state entry, including a restart
    // issued while already in PLL_RST.
    if (restart || (state_n != state)) cnt_n = '0;
  end

  // Outputs are registered from next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_resetb   <= 1'b0;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      retry_count  <= 4'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pll_resetb   <= (state_n != PLL_RST);
      core_reset_n <= (state_n == RUN);
      ready        <= (state_n == RUN);
      if (set_lock_lost) lock_lost <= 1'b1;
      else if (clear_status) lock_lost <= 1'b0;
      if (timeout_evt) begin
        if (retry_count != 4'd15) retry_count <= retry_count + 4'd1;
      end else if (clear_status) begin
        retry_count <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clock;
  logic       reset_n;
  logic       locked;
  logic       restart;
  logic       clear_status;
  logic       pll_resetb;
  logic       core_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;

  int checks;
  int errors;

  pll_reset_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (10),
    .STABLE_CYCLES(8),
    .CNT_WIDTH    (17)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .locked      (locked),
    .restart     (restart),
    .clear_status(clear_status),
    .pll_resetb  (pll_resetb),
    .core_reset_n(core_reset_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // exp = {pll_resetb, core_reset_n, ready, lock_lost, retry_count}
  typedef struct packed {
    logic       locked;
    logic       restart;
    logic       clear_status;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void push(input logic l, input logic rs, input logic cl,
                               input logic p, input logic c, input logic r,
                               input logic ll, input logic [3:0] rc);
    vec_t v;
    v.locked       = l;
    v.restart      = rs;
    v.clear_status = cl;
    v.exp          = {p, c, r, ll, rc};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {pll_resetb, core_reset_n, ready, lock_lost, retry_count};
  endfunction

  task automatic do_reset;
    reset_n      = 1'b0;
    locked       = 1'b0;
    restart      = 1'b0;
    clear_status = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  int exp_rc;

  initial begin
    checks = 0;
    errors = 0;

    // Edges counted from reset release (e1 = first edge).
    repeat (3) push(0, 0, 0, 0, 0, 0, 0, 0);   // e1-e3 PLL_RST
    push(0, 0, 0, 1, 0, 0, 0, 0);              // e4 WAIT_LOCK
    repeat (10) push(1, 0, 0, 1, 0, 0, 0, 0);  // e5-e14 sync + STABLE
    repeat (2) push(1, 0, 0, 1, 1, 1, 0, 0);   // e15-e16 RUN
    repeat (2) push(0, 0, 0, 1, 1, 1, 0, 0);   // e17-e18 drop, synchronizing
    repeat (4) push(0, 0, 0, 0, 0, 0, 1, 0);   // e19-e22 PLL_RST, lock_lost
    push(0, 0, 0, 1, 0, 0, 1, 0);              // e23 WAIT_LOCK
    repeat (10) push(1, 0, 0, 1, 0, 0, 1, 0);  // e24-e33
    push(1, 0, 0, 1, 1, 1, 1, 0);              // e34 RUN, lock_lost kept
    push(1, 0, 1, 1, 1, 1, 0, 0);              // e35 clear_status
    repeat (2) push(0, 0, 0, 1, 1, 1, 0, 0);   // e36-e37 drop, synchronizing
    push(0, 1, 0, 0, 0, 0, 0, 0);              // e38 restart + lock drop
    repeat (3) push(0, 0, 0, 0, 0, 0, 0, 0);   // e39-e41
    push(0, 0, 0, 1, 0, 0, 0, 0);              // e42 WAIT_LOCK
    repeat (3) push(1, 0, 0, 1, 0, 0, 0, 0);   // e43-e45 STABLE entered e45
    push(0, 0, 0, 1, 0, 0, 0, 0);              // e46 one-cycle glitch
    repeat (10) push(1, 0, 0, 1, 0, 0, 0, 0);  // e47-e56 back to WAIT_LOCK, restabilize
    push(1, 0, 0, 1, 1, 1, 0, 0);              // e57 RUN

    reset_n      = 1'b0;
    locked       = 1'b0;
    restart      = 1'b0;
    clear_status = 1'b0;
    repeat (3) tick();
    chk("reset_state", outs(), 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      locked       = vecs[i].locked;
      restart      = vecs[i].restart;
      clear_status = vecs[i].clear_status;
      tick();
      chk($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end
    restart      = 1'b0;
    clear_status = 1'b0;

    // Lock never arrives: 14-cycle retry loop, retry_count saturates.
    do_reset();
    exp_rc = 0;
    for (int k = 1; k <= 21; k++) begin
      clear_status = (k == 6);
      tick();
      clear_status = 1'b0;
      if (k == 6) exp_rc = 0;
      tick();
      tick();
      chk($sformatf("to%0d_rst_low", k), {7'd0, pll_resetb}, 8'd0);
      tick();
      chk($sformatf("to%0d_rst_high", k), {7'd0, pll_resetb}, 8'd1);
      repeat (9) tick();
      chk($sformatf("to%0d_rc_before", k), {4'd0, retry_count}, 8'(exp_rc));
      clear_status = (k == 3);
      tick();
      clear_status = 1'b0;
      exp_rc = (exp_rc == 15) ? 15 : exp_rc + 1;
      chk($sformatf("to%0d_timeout", k), outs(), {4'b0000, 4'(exp_rc)});
    end

    // Async reset while in STABLE.
    locked = 1'b1;
    repeat (8) tick();
    chk("stable_pre_reset", outs(), 8'h8F);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset", outs(), 8'h00);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
